// File: rtl/dcache_resp_pkg.sv
// Shared types for the data-cache responder: FSM states, access sizes,
// store-log entries and the big-endian byte-lane merge.
package dcache_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } log_entry_t;

    // Lane 0 is the most significant byte; right-aligned store data goes into the addressed lane.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] w;
        w = old_word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    w = {wdata[7:0], old_word[23:0]};
                    2'd1:    w = {old_word[31:24], wdata[7:0], old_word[15:0]};
                    2'd2:    w = {old_word[31:16], wdata[7:0], old_word[7:0]};
                    2'd3:    w = {old_word[31:8], wdata[7:0]};
                    default: w = old_word;
                endcase
            end
            SZ_HALF: w = lane[1] ? {old_word[31:16], wdata[15:0]} : {wdata[15:0], old_word[15:0]};
            SZ_WORD: w = wdata;
            default: w = old_word;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dcache_resp_model_if.sv
// Core-side request/response bus plus the store-log read port of the responder.
interface dcache_resp_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic [31:0] dco_data;
    logic        dco_hold;
    logic        dco_mexc;
    logic        dco_werr;
    logic        log_pop;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        log_overflow;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, log_pop,
        input  dco_data, dco_hold, dco_mexc, dco_werr,
        input  log_valid, log_addr, log_data, log_overflow
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, log_pop,
        output dco_data, dco_hold, dco_mexc, dco_werr,
        output log_valid, log_addr, log_data, log_overflow
    );
endinterface

// File: rtl/dcache_resp_model_store_log_fifo.sv
// Store-log FIFO: keeps committed stores in order; a push into a full log is dropped
// and flagged sticky, unless a pop frees the slot on the same edge.
module store_log_fifo
    import dcache_resp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  log_entry_t din,
    output log_entry_t dout,
    output logic       valid,
    output logic       full,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);

    log_entry_t      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            overflow_r;
    logic            pop_ok_s;
    logic            push_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign valid     = (count_r != {(AW+1){1'b0}});
    assign pop_ok_s  = pop && valid;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign dout      = mem_r[rd_ptr_r];
    assign overflow  = overflow_r;

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
            if (push && !push_ok_s) overflow_r <= 1'b1;
        end
    end

    // Entry storage; not reset.
    always_ff @(posedge clk) begin
        if (rst && push_ok_s) mem_r[wr_ptr_r] <= din;
    end

endmodule

// File: rtl/dcache_resp_model.sv
// Data-cache responder: wait-state FSM in front of a word-addressed big-endian RAM,
// with error detection and an in-order log of committed stores.
module dcache_resp_model
    import dcache_resp_pkg::*;
#(
    parameter int          MEM_AW      = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          LOG_DEPTH   = 8
) (
    input logic         clk,
    input logic         rst,
    dcache_resp_if.slave bus
);
    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    state_t            state_r, state_next_s;
    logic [CW-1:0]     cnt_r, cnt_next_s;
    logic              latch_s;
    logic [31:0]       addr_r, wdata_r;
    logic [1:0]        size_r;
    logic              write_r;
    logic [31:0]       acc_addr_s, acc_wdata_s, off_s, rd_word_s;
    logic [1:0]        acc_size_s;
    logic              acc_write_s, err_s, enter_resp_s, log_push_s;
    logic [MEM_AW-1:0] idx_s;
    logic [31:0]       mem_r [2**MEM_AW];
    logic              hold_r, mexc_r, werr_r;
    logic [31:0]       data_r;
    log_entry_t        log_head_s;

    // Next-state and wait counter.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        latch_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    latch_s = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = WAIT;
                        cnt_next_s   = CW'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_next_s = RESP;
                end else begin
                    cnt_next_s = cnt_r - CW'(1);
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // With zero wait states the access happens on the same edge that samples the request.
    assign acc_addr_s   = (state_r == IDLE) ? bus.req_addr  : addr_r;
    assign acc_wdata_s  = (state_r == IDLE) ? bus.req_wdata : wdata_r;
    assign acc_size_s   = (state_r == IDLE) ? bus.req_size  : size_r;
    assign acc_write_s  = (state_r == IDLE) ? bus.req_write : write_r;
    assign enter_resp_s = (state_next_s == RESP);

    assign off_s     = acc_addr_s - BASE_ADDR;
    assign idx_s     = off_s[MEM_AW+1:2];
    assign rd_word_s = mem_r[idx_s];
    assign err_s     = ((off_s >> (MEM_AW + 2)) != 32'd0)
                    || (acc_size_s == SZ_RSVD)
                    || ((acc_size_s == SZ_HALF) && acc_addr_s[0])
                    || ((acc_size_s == SZ_WORD) && (acc_addr_s[1:0] != 2'd0));
    assign log_push_s = rst && enter_resp_s && acc_write_s && !err_s;

    // FSM state, latched request and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            size_r  <= 2'd0;
            write_r <= 1'b0;
            hold_r  <= 1'b1;
            data_r  <= 32'd0;
            mexc_r  <= 1'b0;
            werr_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (latch_s) begin
                addr_r  <= bus.req_addr;
                wdata_r <= bus.req_wdata;
                size_r  <= bus.req_size;
                write_r <= bus.req_write;
            end
            hold_r <= (state_next_s != WAIT);
            data_r <= (enter_resp_s && !acc_write_s && !err_s) ? rd_word_s : 32'd0;
            mexc_r <= enter_resp_s && !acc_write_s && err_s;
            werr_r <= enter_resp_s && acc_write_s && err_s;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (log_push_s) mem_r[idx_s] <= lane_merge(rd_word_s, acc_wdata_s, acc_size_s, acc_addr_s[1:0]);
    end

    store_log_fifo #(.DEPTH(LOG_DEPTH)) u_log (
        .clk      (clk),
        .rst      (rst),
        .push     (log_push_s),
        .pop      (bus.log_pop),
        .din      ({acc_addr_s, acc_wdata_s}),
        .dout     (log_head_s),
        .valid    (bus.log_valid),
        .full     (),
        .overflow (bus.log_overflow)
    );

    assign bus.dco_hold = hold_r;
    assign bus.dco_data = data_r;
    assign bus.dco_mexc = mexc_r;
    assign bus.dco_werr = werr_r;
    assign bus.log_addr = log_head_s.addr;
    assign bus.log_data = log_head_s.data;

endmodule
